// File: rtl/ssg_control.sv
// Scans the 0-15 score onto an 8-digit active-low seven-segment display as decimal, with the tens digit blanked below 10.
// Outputs are registered one cycle behind the slot counter and score register; there is no backpressure and the scan is free-running.
module ssg_control #(
   parameter int REFRESH_DIV = 100000
) (
   input  logic       SSG_control_clk,
   input  logic       SSG_control_reset,
   input  logic [3:0] SSG_control_score0,
   output logic [7:0] SSG_control_anode,
   output logic [6:0] SSG_control_cathodes
);

   localparam int DW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);

   logic [3:0]    r_score_q;
   logic [DW-1:0] r_div_cnt;
   logic [2:0]    r_slot;
   logic [7:0]    r_anode;
   logic [6:0]    r_cathodes;

   logic          w_tick;
   logic          w_tens;
   logic [3:0]    w_ones;
   logic [6:0]    w_seg_ones;
   logic [7:0]    w_anode_nxt;
   logic [6:0]    w_cath_nxt;

   assign w_tick = (r_div_cnt == DIV_LAST);
   assign w_tens = (r_score_q >= 4'd10);
   assign w_ones = w_tens ? (r_score_q - 4'd10) : r_score_q;

   always_comb begin
      w_seg_ones = 7'h7F;
      case (w_ones)
         4'd0:    w_seg_ones = 7'h40;
         4'd1:    w_seg_ones = 7'h79;
         4'd2:    w_seg_ones = 7'h24;
         4'd3:    w_seg_ones = 7'h30;
         4'd4:    w_seg_ones = 7'h19;
         4'd5:    w_seg_ones = 7'h12;
         4'd6:    w_seg_ones = 7'h02;
         4'd7:    w_seg_ones = 7'h78;
         4'd8:    w_seg_ones = 7'h00;
         4'd9:    w_seg_ones = 7'h10;
         default: w_seg_ones = 7'h7F;
      endcase
   end

   // Only slots 0 and 1 ever light; the tens digit can only be a "1".
   always_comb begin
      w_anode_nxt = 8'hFF;
      w_cath_nxt  = 7'h7F;
      if (r_slot == 3'd0) begin
         w_anode_nxt = 8'hFE;
         w_cath_nxt  = w_seg_ones;
      end else if ((r_slot == 3'd1) && w_tens) begin
         w_anode_nxt = 8'hFD;
         w_cath_nxt  = 7'h79;
      end
   end

   always_ff @(posedge SSG_control_clk) begin
      if (SSG_control_reset) begin
         r_score_q  <= 4'd0;
         r_div_cnt  <= '0;
         r_slot     <= 3'd0;
         r_anode    <= 8'hFF;
         r_cathodes <= 7'h7F;
      end else begin
         r_score_q  <= SSG_control_score0;
         r_div_cnt  <= w_tick ? '0 : (r_div_cnt + DW'(1));
         if (w_tick) begin
            r_slot <= r_slot + 3'd1;
         end
         r_anode    <= w_anode_nxt;
         r_cathodes <= w_cath_nxt;
      end
   end

   assign SSG_control_anode    = r_anode;
   assign SSG_control_cathodes = r_cathodes;

endmodule

// File: tb/tb_ssg_control.sv
// Randomized bench for ssg_control with a queue-based scoreboard and an arithmetic reference model.
module tb_ssg_control;

   localparam int DIV = 4;

   logic       clk;
   logic       rst_i;
   logic [3:0] score_i;
   logic [7:0] anode_o;
   logic [6:0] cath_o;

   ssg_control #(.REFRESH_DIV(DIV)) dut (
      .SSG_control_clk      (clk),
      .SSG_control_reset    (rst_i),
      .SSG_control_score0   (score_i),
      .SSG_control_anode    (anode_o),
      .SSG_control_cathodes (cath_o)
   );

   initial clk = 1'b1;
   always #5 clk = ~clk;

   logic [14:0] exp_q[$];
   logic [6:0]  pat [10];
   int          n_checks = 0;
   int          n_pass   = 0;
   int          m_cnt    = 0;
   int          m_prev   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference: the slot is the number of edges since reset divided by DIV, modulo 8.
   task automatic drive(input logic rst, input logic [3:0] sc);
      logic [7:0] ea;
      logic [6:0] ec;
      int slot;
      @(negedge clk);
      rst_i   = rst;
      score_i = sc;
      ea = 8'hFF;
      ec = 7'h7F;
      if (rst) begin
         m_cnt  = 0;
         m_prev = 0;
      end else begin
         slot = (m_cnt / DIV) % 8;
         if (slot == 0) begin
            ea = 8'hFE;
            ec = pat[m_prev % 10];
         end else if (slot == 1 && m_prev >= 10) begin
            ea = 8'hFD;
            ec = pat[1];
         end
         m_cnt++;
         m_prev = int'(sc);
      end
      exp_q.push_back({ea, ec});
   endtask

   initial begin
      logic [14:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("anode", int'(anode_o), int'(e[14:7]));
            check("cathodes", int'(cath_o), int'(e[6:0]));
            check("one_anode_low", ($countones(~anode_o) <= 1) ? 1 : 0, 1);
         end
      end
   end

   initial begin
      int guard;
      pat[0] = 7'h40; pat[1] = 7'h79; pat[2] = 7'h24; pat[3] = 7'h30; pat[4] = 7'h19;
      pat[5] = 7'h12; pat[6] = 7'h02; pat[7] = 7'h78; pat[8] = 7'h00; pat[9] = 7'h10;
      rst_i   = 1'b1;
      score_i = 4'd5;

      repeat (3) drive(1'b1, 4'd5);
      repeat (8 * DIV + 1) drive(1'b0, 4'd7);
      repeat (8 * DIV) drive(1'b0, 4'd13);
      for (int s = 0; s < 16; s++) begin
         repeat (8 * DIV) drive(1'b0, 4'(s));
      end

      guard = 0;
      while (((m_cnt / DIV) % 8) != 5 && guard < 64) begin
         drive(1'b0, 4'(12));
         guard++;
      end
      check("reach_slot5", (((m_cnt / DIV) % 8) == 5) ? 1 : 0, 1);
      drive(1'b0, 4'd14);
      drive(1'b1, 4'd14);
      repeat (2 * 8 * DIV) drive(1'b0, 4'd11);

      for (int i = 0; i < 600; i++) begin
         drive(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0, 4'($urandom_range(0, 15)));
      end

      @(negedge clk);
      rst_i = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
